nand_rr_scheduler: RTL



---
 rtl/nand_rr_scheduler_pkg.sv | 58 +++++
 rtl/nand_rr_scheduler_if.sv | 41 ++++
 rtl/nand_unit.sv | 22 ++
 rtl/nand_rr_scheduler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/nand_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_sched_pkg
// Description : Shared types and helpers for the round-robin NAND scheduler:
//               FSM state encoding, default sizing, and the round-robin
//               search used to pick the next requester.
// Contents    : state_t, rr_sel_t, rr_next(), rr_pick()
// Revision    : 1.0 - initial release
// ============================================================================
package nand_sched_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 1;
    // Upper bound on requesters; the search helper works on this fixed width.
    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_sel_t;

    // Index following idx, wrapping at n.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input int unsigned      n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // First set bit of pend, searching from ptr+1 and wrapping modulo n.
    function automatic rr_sel_t rr_pick(input logic [MAX_REQ-1:0] pend,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int unsigned        n);
        rr_sel_t          sel;
        logic [IDX_W-1:0] cand;
        sel  = '0;
        cand = ptr;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                cand = rr_next(cand, n);
                if (!sel.found && pend[cand]) begin
                    sel.found = 1'b1;
                    sel.idx   = cand;
                end
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : nand_rr_scheduler_if
// Description : Request/grant/result bundle between the requesters and the
//               shared NAND scheduler.
// Signals     : ena, req, op_a, op_b (requester side -> scheduler)
//               gnt, res_valid, res_id, res_y, busy, err_ovf (scheduler ->)
// Modports    : master (requester side), slave (scheduler)
// Revision    : 1.0 - initial release
// ============================================================================
interface nand_rr_scheduler_if
    import nand_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int ID_W = $clog2(N_REQ);

    logic                   ena;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ-1:0]       gnt;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [WIDTH-1:0]       res_y;
    logic                   busy;
    logic                   err_ovf;

    modport master (
        output ena, req, op_a, op_b,
        input  gnt, res_valid, res_id, res_y, busy, err_ovf
    );

    modport slave (
        input  ena, req, op_a, op_b,
        output gnt, res_valid, res_id, res_y, busy, err_ovf
    );

endinterface
`default_nettype wire

// File: rtl/nand_unit.sv
`default_nettype none
// ============================================================================
// Module      : nand_unit
// Description : Combinational bitwise NAND; the single evaluation resource
//               shared by all requesters.
// Ports       : a_i, b_i (WIDTH operands), y_o (WIDTH result = ~(a & b))
// Revision    : 1.0 - initial release
// ============================================================================
module nand_unit
    import nand_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    output logic      [WIDTH-1:0] y_o
);

    assign y_o = ~(a_i & b_i);

endmodule
`default_nettype wire

// File: rtl/nand_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nand_rr_scheduler
// Description : Round-robin scheduler sharing one NAND unit among N_REQ
//               requesters. Requests are latched as pending bits, granted one
//               at a time (IDLE -> EVAL), and returned as a tagged registered
//               result one cycle after the grant.
// Ports       : clk, rst_n (async assert, active low)
//               bus (slave modport): ena, req, op_a, op_b in;
//               gnt, res_valid, res_id, res_y, busy, err_ovf out
// Revision    : 1.0 - initial release
// ============================================================================
module nand_rr_scheduler
    import nand_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    nand_rr_scheduler_if.slave  bus
);

    localparam int ID_W = $clog2(N_REQ);

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     pending_q, pending_d, pend_clr;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      res_id_q, res_id_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]     res_y_q, res_y_d;
    logic                 res_valid_q, res_valid_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     nand_y;

    logic [MAX_REQ-1:0]   pend_ext;
    logic [IDX_W-1:0]     ptr_ext;
    rr_sel_t              sel;

    nand_unit #(.WIDTH(WIDTH)) u_nand (
        .a_i (a_q),
        .b_i (b_q),
        .y_o (nand_y)
    );

    // Widen to the fixed search width so one helper serves every N_REQ.
    always_comb begin
        pend_ext                = '0;
        pend_ext[N_REQ-1:0]     = pending_q;
        ptr_ext                 = '0;
        ptr_ext[ID_W-1:0]       = ptr_q;
        sel                     = rr_pick(pend_ext, ptr_ext, N_REQ);
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        pend_clr    = '0;
        id_d        = id_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_y_d     = res_y_q;
        case (state_q)
            IDLE: begin
                if (bus.ena && sel.found) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (sel.idx == IDX_W'(i)) begin
                            gnt_d[i]    = 1'b1;
                            pend_clr[i] = 1'b1;
                            id_d        = ID_W'(i);
                            ptr_d       = ID_W'(i);
                            a_d         = bus.op_a[i*WIDTH +: WIDTH];
                            b_d         = bus.op_b[i*WIDTH +: WIDTH];
                        end
                    end
                    state_d = EVAL;
                end
            end
            EVAL: begin
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                res_y_d     = nand_y;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new request at its own grant edge re-arms the pending bit; a request
    // for an already-pending, non-granted requester is dropped and flagged.
    assign pending_d = (pending_q & ~pend_clr) | bus.req;
    assign err_d     = err_q | (|(bus.req & pending_q & ~pend_clr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            gnt_q       <= '0;
            ptr_q       <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_y_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_y_q     <= res_y_d;
            err_q       <= err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_y     = res_y_q;
    assign bus.err_ovf   = err_q;
    assign bus.busy      = (|pending_q) | (state_q == EVAL);

endmodule
`default_nettype wire
